// File: rtl/alu_pkg.sv
// Shared ALU constants: datapath width and the 3-bit operation codes used by
// the decoder, the control unit and the ALU itself.
package alu_pkg;

    localparam int WORD_WIDTH = 16;

    typedef enum logic [0:2] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_MUL   = 3'd2,
        ALU_SLT   = 3'd3,
        ALU_AND   = 3'd4,
        ALU_OR    = 3'd5,
        ALU_XOR   = 3'd6,
        ALU_SHIFT = 3'd7
    } alu_op_e;

endpackage

// File: rtl/alu_shifter.sv
// Bidirectional logical shifter: a non-negative count shifts left, a negative
// count shifts right by its magnitude, and any |count| >= WORD_WIDTH yields zero.
module alu_shifter #(
    parameter int WORD_WIDTH = alu_pkg::WORD_WIDTH
) (
    input  logic [0:WORD_WIDTH-1] a,
    input  logic [0:WORD_WIDTH-1] count,
    output logic [0:WORD_WIDTH-1] result
);

    localparam logic [0:WORD_WIDTH-1] LIMIT = WORD_WIDTH'(WORD_WIDTH);

    logic                  negative;
    logic [0:WORD_WIDTH-1] magnitude;

    // The most negative count has no positive twin; its magnitude still reads
    // as >= LIMIT when taken as unsigned, so it falls into the zero case.
    always_comb begin
        negative  = count[0];
        magnitude = negative ? -count : count;
        if (magnitude >= LIMIT) begin
            result = '0;
        end else if (negative) begin
            result = a >> magnitude;
        end else begin
            result = a << magnitude;
        end
    end

endmodule

// File: rtl/alu.sv
// Single-cycle integer ALU: result of op on in1/in2 is registered into out on
// every rising edge, giving exactly one cycle of latency and no handshake.
module alu #(
    parameter int WORD_WIDTH = alu_pkg::WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [0:2]            op,
    input  logic [0:WORD_WIDTH-1] in1,
    input  logic [0:WORD_WIDTH-1] in2,
    output logic [0:WORD_WIDTH-1] out
);
    import alu_pkg::*;

    alu_op_e               op_sel;
    logic [0:WORD_WIDTH-1] shift_result;
    logic [0:WORD_WIDTH-1] result_next;
    logic                  less_than;

    assign op_sel    = alu_op_e'(op);
    assign less_than = $signed(in1) < $signed(in2);

    alu_shifter #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_shifter (
        .a     (in1),
        .count (in2),
        .result(shift_result)
    );

    // Arithmetic wraps modulo 2^WORD_WIDTH; the low product half is sign-agnostic.
    always_comb begin
        result_next = '0;
        case (op_sel)
            ALU_ADD:   result_next = in1 + in2;
            ALU_SUB:   result_next = in1 - in2;
            ALU_MUL:   result_next = in1 * in2;
            ALU_SLT:   result_next = {{(WORD_WIDTH-1){1'b0}}, less_than};
            ALU_AND:   result_next = in1 & in2;
            ALU_OR:    result_next = in1 | in2;
            ALU_XOR:   result_next = in1 ^ in2;
            ALU_SHIFT: result_next = shift_result;
            default:   result_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out <= '0;
        end else begin
            out <= result_next;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases, a back-to-back latency run,
// reset behaviour, then randomized operations against an arithmetic model.
module tb_alu;
    import alu_pkg::*;

    localparam int W = WORD_WIDTH;

    logic         clk;
    logic         reset;
    logic [0:2]   op;
    logic [0:W-1] in1;
    logic [0:W-1] in2;
    logic [0:W-1] out;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           n_checks = 0;
    int           n_errors = 0;

    alu #(.WORD_WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .op   (op),
        .in1  (in1),
        .in2  (in2),
        .out  (out)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic longint to_signed(longint v);
        return (v >= (64'sd1 << (W - 1))) ? v - (64'sd1 << W) : v;
    endfunction

    function automatic logic [W-1:0] model(int o, longint a, longint b);
        longint modv;
        longint r;
        longint sb;
        modv = 64'sd1 << W;
        sb   = to_signed(b);
        r    = 0;
        case (o)
            0: r = a + b;
            1: r = a - b + modv;
            2: r = a * b;
            3: r = (to_signed(a) < sb) ? 1 : 0;
            4: r = a & b;
            5: r = a | b;
            6: r = a ^ b;
            7: begin
                if (sb >= 0 && sb < W)      r = a * (64'sd1 << sb);
                else if (sb < 0 && -sb < W) r = a / (64'sd1 << (-sb));
                else                        r = 0;
            end
            default: r = 0;
        endcase
        return W'(r % modv);
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic check_pending();
        if (exp_q.size() > 0) begin
            check(tag_q.pop_front(), out, exp_q.pop_front());
        end
    endtask

    // ---------------- driver ----------------
    // At each falling edge: check the result captured at the previous rising
    // edge, then present the next operation with its expected result.
    task automatic drive(input logic rst, input logic [0:2] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp, input string tag);
        @(negedge clk);
        check_pending();
        reset = rst;
        op    = o;
        in1   = a;
        in2   = b;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic drive_model(input logic rst, input logic [0:2] o, input logic [W-1:0] a,
                               input logic [W-1:0] b, input string tag);
        drive(rst, o, a, b, rst ? '0 : model(int'(o), longint'(a), longint'(b)), tag);
    endtask

    function automatic logic [W-1:0] rand_operand(int o);
        int kind;
        kind = $urandom_range(0, 3);
        if (o == 7 && kind == 3) return W'($urandom_range(0, 40) - 20);
        case (kind)
            0: return W'($urandom);
            1: return W'($urandom_range(0, 20));
            2: return ($urandom_range(0, 1) == 1) ? '1 : W'(16'h8000);
            default: return W'($urandom);
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        op    = '0;
        in1   = '0;
        in2   = '0;

        drive(1'b1, ALU_ADD, 16'h0000, 16'h0000, 16'h0000, "reset_0");
        drive(1'b1, ALU_ADD, 16'h0000, 16'h0000, 16'h0000, "reset_1");

        drive(1'b0, ALU_ADD,   16'd5,    16'd7,    16'd12,    "add_basic");
        drive(1'b0, ALU_SUB,   16'd15,   16'd4,    16'd11,    "sub_basic");
        drive(1'b0, ALU_MUL,   16'd4,    16'd9,    16'd36,    "mul_basic");
        drive(1'b0, ALU_SLT,   16'd5,    16'd7,    16'd1,     "slt_basic");
        drive(1'b0, ALU_AND,   16'd9,    16'd12,   16'd8,     "and_basic");
        drive(1'b0, ALU_OR,    16'd9,    16'd12,   16'd13,    "or_basic");
        drive(1'b0, ALU_XOR,   16'd9,    16'd12,   16'd5,     "xor_basic");
        drive(1'b0, ALU_SHIFT, 16'd5,    16'd3,    16'd40,    "shift_basic");

        drive(1'b0, ALU_ADD,   16'hFFFF, 16'h0001, 16'h0000,  "add_wrap");
        drive(1'b0, ALU_SUB,   16'h0000, 16'h0001, 16'hFFFF,  "sub_wrap");
        drive(1'b0, ALU_MUL,   16'h0100, 16'h0100, 16'h0000,  "mul_wrap");
        drive(1'b0, ALU_SLT,   16'hFFFF, 16'h0001, 16'h0001,  "slt_neg_pos");
        drive(1'b0, ALU_SLT,   16'h0001, 16'hFFFF, 16'h0000,  "slt_pos_neg");
        drive(1'b0, ALU_SLT,   16'd7,    16'd7,    16'h0000,  "slt_equal");

        drive(1'b0, ALU_SHIFT, 16'h8001, 16'hFFFF, 16'h4000,  "shr_1");
        drive(1'b0, ALU_SHIFT, 16'h0001, 16'd15,   16'h8000,  "shl_15");
        drive(1'b0, ALU_SHIFT, 16'h0001, 16'd16,   16'h0000,  "shl_16");
        drive(1'b0, ALU_SHIFT, 16'h8000, 16'hFFF0, 16'h0000,  "shr_16");
        drive(1'b0, ALU_SHIFT, 16'h8000, 16'hFFF1, 16'h0001,  "shr_15");
        drive(1'b0, ALU_SHIFT, 16'h1234, 16'h0000, 16'h1234,  "shift_0");

        drive(1'b0, ALU_ADD,   16'd1,    16'd1,    16'd2,     "lat_add");
        drive(1'b0, ALU_SUB,   16'd9,    16'd2,    16'd7,     "lat_sub");
        drive(1'b0, ALU_AND,   16'd6,    16'd3,    16'd2,     "lat_and");

        drive(1'b1, ALU_ADD,   16'd5,    16'd7,    16'd0,     "rst_hold_0");
        drive(1'b1, ALU_ADD,   16'd5,    16'd7,    16'd0,     "rst_hold_1");
        drive(1'b0, ALU_ADD,   16'd5,    16'd7,    16'd12,    "rst_release");
        drive(1'b0, ALU_SUB,   16'd9,    16'd2,    16'd7,     "pre_mid_rst");
        drive(1'b1, ALU_AND,   16'd6,    16'd3,    16'd0,     "rst_mid");
        drive(1'b0, ALU_OR,    16'd9,    16'd12,   16'd13,    "post_mid_rst");

        for (int i = 0; i < 400; i++) begin
            int           o;
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic         r;
            o = $urandom_range(0, 7);
            a = rand_operand(o);
            b = rand_operand(o);
            r = ($urandom_range(0, 19) == 0);
            drive_model(r, 3'(o), a, b, $sformatf("rand_%0d_op%0d", i, o));
        end

        @(negedge clk);
        check_pending();
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: got %0d left expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Single-cycle integer ALU for the CPU datapath.
- Computes one of eight operations on two WORD_WIDTH operands.
- Registers the result on the rising clock edge, so `out` is valid one cycle after `op`/`in1`/`in2` are presented.
- Sits between the register-file read ports and the writeback mux.

Parameters:
- WORD_WIDTH, 16, operand/result width in bits. Vectors are declared [0:WORD_WIDTH-1]; bit 0 is the MSB.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- op  input  3  operation select ([0:2], bit 0 MSB), encoding below.
- in1  input  WORD_WIDTH  first operand A.
- in2  input  WORD_WIDTH  second operand B.
- out  output  WORD_WIDTH  registered result.

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Op encoding (shared constants):
  - ALU_ADD=0
  - ALU_SUB=1
  - ALU_MUL=2
  - ALU_SLT=3
  - ALU_AND=4
  - ALU_OR=5
  - ALU_XOR=6
  - ALU_SHIFT=7
- ADD: A+B, modulo 2^WORD_WIDTH; carry discarded.
- SUB: A-B, modulo 2^WORD_WIDTH; borrow discarded.
- MUL: low WORD_WIDTH bits of A*B. Identical for signed and unsigned operands.
- SLT: 1 if A<B as two's-complement signed, else 0. Result zero-extended.
- AND, OR, XOR: bitwise.
- SHIFT: B is a signed shift count.
  - B in 0..WORD_WIDTH-1: out = A shifted left logically by B (zero fill).
  - B in -(WORD_WIDTH-1)..-1: out = A shifted right logically by -B (zero fill).
  - |B| >= WORD_WIDTH: out = 0.
- Timing:
  - Result is computed combinationally from the current op/in1/in2 and captured into `out` at the rising clk edge.
  - Latency is exactly 1 cycle. Throughput is one operation per cycle; there is no handshake.
- Reset:
  - When reset=1 at a rising edge, out <= 0 regardless of op and inputs.
  - Reset mid-stream drops the pending result. The first result after reset is released is for the inputs present at the first non-reset edge.
- Output holds its value between edges. Unknown/X on inputs is not propagated specially.
- No flags output. Overflow is silently wrapped.

Decomposition:
- Shared include/package (parameters.v): WORD_WIDTH and the eight ALU_* 3-bit op codes. The decoder, control unit and benches use the same constants.
- One natural sub-module: alu_shifter (combinational; A, signed count B -> shifted word). Keeps the bidirectional and out-of-range shift logic isolated.
- All other operations are inline in a case statement on op, feeding the output register.

Test Plan:
- Basic ops, each presented for one cycle, checked one cycle later. All must match:
  - ADD 5,7 -> 12
  - SUB 15,4 -> 11
  - MUL 4,9 -> 36
  - SLT 5,7 -> 1
  - AND 9,12 -> 8
  - OR 9,12 -> 13
  - XOR 9,12 -> 5
  - SHIFT 5,3 -> 40
- Wrap/sign cases:
  - ADD 0xFFFF,1 -> 0
  - SUB 0,1 -> 0xFFFF
  - MUL 0x0100,0x0100 -> 0
  - SLT 0xFFFF(-1),1 -> 1
  - SLT 1,0xFFFF -> 0
  - SLT 7,7 -> 0
- Shift boundaries:
  - SHIFT 0x8001,0xFFFF(-1) -> 0x4000
  - SHIFT 1,15 -> 0x8000
  - SHIFT 1,16 -> 0
  - SHIFT 0x8000,0xFFF0(-16) -> 0
  - SHIFT 0x1234,0 -> 0x1234
- Latency: change op/operands every cycle (ADD 1,1 then SUB 9,2 then AND 6,3). `out` sequence one cycle behind: 2, 7, 2. No bubbles.
- Reset: drive ADD 5,7 with reset=1 for 2 cycles -> out=0 on both edges. Deassert -> out=12 after the next edge. Assert reset mid-stream -> out=0 at that edge.
